// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: single-cycle handshake to instruction memory and the
// IF/ID pipeline register, with a one-entry buffer to park a word fetched under stall.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request issued at PC; result goes straight into IF/ID
// HOLD  | word returned under stall is parked in the buffers; no request
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        fetch_busy,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_valid
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state_q;
    logic [31:0] instr_buf_q;
    logic [31:0] pc_buf_q;

    assign imem_addr = PC;
    assign imem_req  = rst && (state_q == FETCH);

    // Flush must let the PC take the branch target, so it clears busy in either state.
    always_comb begin
        fetch_busy = 1'b1;
        if (rst) begin
            if (flush) begin
                fetch_busy = 1'b0;
            end else if (state_q == FETCH) begin
                fetch_busy = !(imem_ready && !stall);
            end else begin
                fetch_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q     <= FETCH;
            instr_buf_q <= 32'd0;
            pc_buf_q    <= 32'd0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_PC    <= 32'd0;
            IF_ID_PC4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            state_q     <= FETCH;
            instr_buf_q <= 32'd0;
            pc_buf_q    <= 32'd0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            IF_ID_instr <= imem_rdata;
                            IF_ID_PC    <= PC;
                            IF_ID_PC4   <= PC + 32'd4;
                            IF_ID_valid <= 1'b1;
                        end else begin
                            IF_ID_instr <= NOP_INSTR;
                            IF_ID_valid <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        instr_buf_q <= imem_rdata;
                        pc_buf_q    <= PC;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        IF_ID_instr <= instr_buf_q;
                        IF_ID_PC    <= pc_buf_q;
                        IF_ID_PC4   <= pc_buf_q + 32'd4;
                        IF_ID_valid <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, memory wait, stall capture,
// flush in both states, PC+4 wrap and reset during HOLD.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        flush;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fetch_busy;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    if_fetch_stage dut (
        .CLK         (CLK),
        .rst         (rst),
        .PC          (PC),
        .flush       (flush),
        .stall       (stall),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .fetch_busy  (fetch_busy),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_PC    (IF_ID_PC),
        .IF_ID_PC4   (IF_ID_PC4),
        .IF_ID_valid (IF_ID_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle (after negedge), settle, leaving the edge to the caller.
    task automatic drive(input logic r, input logic [31:0] pc, input logic f, input logic s,
                         input logic rdy, input logic [31:0] rd);
        @(negedge CLK);
        rst = r; PC = pc; flush = f; stall = s; imem_ready = rdy; imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic v);
        check({tag, ".instr"}, IF_ID_instr, ins);
        check({tag, ".pc"},    IF_ID_PC, pc);
        check({tag, ".pc4"},   IF_ID_PC4, pc4);
        check({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b0; PC = 32'd0; flush = 1'b0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'd0;

        // reset
        drive(1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h00500093);
        check("rst.req",  {31'd0, imem_req}, 32'd0);
        check("rst.busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        check_ifid("rst", NOP, 32'd0, 32'd0, 1'b0);

        // streaming, first cycle out of reset
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h00500093);
        check("str.req",  {31'd0, imem_req}, 32'd1);
        check("str.addr", imem_addr, 32'h100);
        check("str.busy", {31'd0, fetch_busy}, 32'd0);
        tick();
        check_ifid("str", 32'h00500093, 32'h100, 32'h104, 1'b1);

        // memory wait two cycles, then ready
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'hBAD0BAD0);
            check("wait.busy", {31'd0, fetch_busy}, 32'd1);
            check("wait.req",  {31'd0, imem_req}, 32'd1);
            tick();
            check_ifid("wait", NOP, 32'h100, 32'h104, 1'b0);
        end
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'h11111111);
        check("wait3.busy", {31'd0, fetch_busy}, 32'd0);
        tick();
        check_ifid("wait3", 32'h11111111, 32'h200, 32'h204, 1'b1);

        // stall capture
        drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'hAABBCCDD);
        check("cap.busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        check_ifid("cap", 32'h11111111, 32'h200, 32'h204, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h999, 1'b0, 1'b1, 1'b1, 32'h55555555);
            check("hold.req",  {31'd0, imem_req}, 32'd0);
            check("hold.busy", {31'd0, fetch_busy}, 32'd1);
            tick();
            check_ifid("hold", 32'h11111111, 32'h200, 32'h204, 1'b1);
        end
        drive(1'b1, 32'h999, 1'b0, 1'b0, 1'b1, 32'h55555555);
        check("rel.req",  {31'd0, imem_req}, 32'd0);
        check("rel.busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        check_ifid("rel", 32'hAABBCCDD, 32'h300, 32'h304, 1'b1);

        // flush in HOLD with stall held
        drive(1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        drive(1'b1, 32'h400, 1'b1, 1'b1, 1'b1, 32'h66666666);
        check("flh.busy", {31'd0, fetch_busy}, 32'd0);
        tick();
        check_ifid("flh", NOP, 32'h300, 32'h304, 1'b0);
        drive(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h77777777);
        check("flh2.req", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("flh2", NOP, 32'h300, 32'h304, 1'b0);

        // flush in FETCH beats a ready word
        drive(1'b1, 32'h900, 1'b1, 1'b0, 1'b1, 32'h12345678);
        check("flf.busy", {31'd0, fetch_busy}, 32'd0);
        tick();
        check_ifid("flf", NOP, 32'h300, 32'h304, 1'b0);

        // PC+4 wrap
        drive(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 32'h00000033);
        tick();
        check_ifid("wrap", 32'h00000033, 32'hFFFFFFFC, 32'h00000000, 1'b1);

        // reset during HOLD
        drive(1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
        tick();
        drive(1'b0, 32'h500, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        check("rsth.req",  {31'd0, imem_req}, 32'd0);
        check("rsth.busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        check_ifid("rsth", NOP, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'h0);
        check("rsth1.req", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("rsth1", NOP, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_ifid("rsth2", NOP, 32'd0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
